pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed 16-bit PC register.
- Holds the fetch PC and selects the next PC each cycle from these sources: sequential increment, branch, jump, call, return and an external redirect.
- Contains an internal return-address stack (RAS) for call/return.
- Sits between the control/branch logic and instruction memory; `pc` drives the fetch address directly.

Parameters:
- WIDTH, 16, PC and target width in bits.
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits).
- STEP, 1, sequential increment per cycle (instruction size in address units).
- RAS_DEPTH, 4, number of return-address stack entries (>=2).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hold PC and RAS this cycle (redirect still honoured).
- redirect  in  1  load redirect_target unconditionally (exception/interrupt vector).
- redirect_target  in  WIDTH  redirect destination.
- branch  in  1  taken branch: PC <- target.
- jump  in  1  unconditional jump: PC <- target.
- call  in  1  push PC+STEP onto the RAS, then PC <- target.
- ret  in  1  PC <- popped RAS entry.
- target  in  WIDTH  absolute destination shared by branch/jump/call.
- err_clear  in  1  clears the sticky ras_overflow/ras_underflow flags.
- pc  out  WIDTH  current PC (registered).
- ras_count  out  clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_empty  out  1  ras_count==0.
- ras_full  out  1  ras_count==RAS_DEPTH.
- ras_overflow  out  1  sticky: a call was made while the RAS was full.
- ras_underflow  out  1  sticky: a ret was made while the RAS was empty.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_VECTOR, ras_count=0, RAS write pointer=0.
  - ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - Applies immediately and mid-operation; the first update is on the first rising edge after reset goes high.
- All updates occur on the rising clock edge. Latency is 1 cycle: a control input sampled at edge N is visible on pc after edge N.
- Next-PC priority, highest first:
  1. redirect: pc<=redirect_target. RAS untouched. Overrides stall and all other controls.
  2. stall: pc and RAS hold. All other controls ignored; upstream must hold them.
  3. ret: if the RAS is non-empty, pc<=top entry and ras_count decrements. If empty, pc<=pc+STEP and ras_underflow<=1.
  4. call: push pc+STEP, then pc<=target.
  5. jump or branch: pc<=target.
  6. otherwise: pc<=pc+STEP.
- Simultaneous ret+call: ret wins; no push occurs.
- Simultaneous call+jump/branch: treated as call.
- RAS is circular:
  - push writes at the write pointer, then the pointer increments modulo RAS_DEPTH.
  - pop reads entry (pointer-1) mod RAS_DEPTH, then the pointer decrements.
- Call when full: the oldest entry is overwritten, ras_count stays at RAS_DEPTH, and ras_overflow<=1.
- Arithmetic: pc+STEP is computed modulo 2^WIDTH, so the PC silently wraps from max to 0 (e.g. 16'hFFFF+1 -> 16'h0000). No flag is raised.
- The pushed return address wraps the same way.
- Sticky flags:
  - Set only by the events above; cleared only by reset or err_clear.
  - If err_clear and a setting event coincide, set wins.
- All outputs are registered or decoded directly from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/increment: hold reset=0, then release with STEP=1, RESET_VECTOR=0 -> pc=0, then 1,2,3 on successive edges. Assert reset mid-count at pc=5 -> pc=0 immediately, without waiting for a clock edge.
- Wrap: redirect to 16'hFFFE, then free-run -> pc=FFFE, FFFF, 0000, 0001. No flags set.
- Stall vs redirect:
  - stall=1 with jump=1, target=0x40 at pc=0x10 -> pc stays 0x10.
  - Then stall=1, redirect=1, redirect_target=0x80 -> pc=0x80.
- Call/return nesting: at pc=0x10 call target=0x100; at pc=0x101 call 0x200; ret; ret.
  - Required pc sequence: 0x100, 0x101, 0x200, 0x102, 0x11.
  - Required ras_count sequence: 1, 1, 2, 1, 0.
- Overflow (RAS_DEPTH=4): 5 nested calls -> ras_full=1, ras_overflow=1, ras_count=4. Then 4 rets return to call sites 5..2 (each pc+STEP); the 5th ret increments pc and sets ras_underflow=1.
- Priority/clear:
  - ret+call together -> ret taken, no push.
  - err_clear=1 with no event -> both flags drop to 0 next edge.
  - err_clear during a setting event -> the flag stays 1.

Source files
------------

// File: rtl/pc_unit_if.sv
// Control/status bundle between the branch/control logic and the program-counter unit.
interface pc_unit_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic             branch;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic             err_clear;

  logic [WIDTH-1:0] pc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, redirect, redirect_target, branch, jump, call, ret, target, err_clear,
    input  pc, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, redirect, redirect_target, branch, jump, call, ret, target, err_clear,
    output pc, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC select and a circular return-address stack.
module pc_unit #(
  parameter int unsigned          WIDTH        = 16,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned          STEP         = 1,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic          clock,
  input  logic          reset,
  pc_unit_if.slave      bus
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);

  logic [WIDTH-1:0] ras [RAS_DEPTH];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             overflow_q, underflow_q;

  logic [WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic             push;
  logic             overflow_set, underflow_set;
  logic             ras_empty_w, ras_full_w;

  assign pc_inc      = pc_q + STEP_W;
  assign ptr_inc     = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec     = (ptr_q == '0) ? LAST_PTR : ptr_q - PTR_W'(1);
  assign ras_empty_w = (count_q == '0);
  assign ras_full_w  = (count_q == DEPTH_C);

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    ptr_d         = ptr_q;
    push          = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;

    if (bus.redirect) begin
      pc_d = bus.redirect_target;
    end else if (!bus.stall) begin
      if (bus.ret) begin
        if (ras_empty_w) begin
          pc_d          = pc_inc;
          underflow_set = 1'b1;
        end else begin
          pc_d    = ras[ptr_dec];
          count_d = count_q - CNT_W'(1);
          ptr_d   = ptr_dec;
        end
      end else if (bus.call) begin
        // A full stack has its write pointer on the oldest entry, so the push overwrites it.
        push  = 1'b1;
        ptr_d = ptr_inc;
        pc_d  = bus.target;
        if (ras_full_w) overflow_set = 1'b1;
        else            count_d      = count_q + CNT_W'(1);
      end else if (bus.jump || bus.branch) begin
        pc_d = bus.target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      count_q     <= '0;
      ptr_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      overflow_q  <= overflow_set  | (overflow_q  & ~bus.err_clear);
      underflow_q <= underflow_set | (underflow_q & ~bus.err_clear);
    end
  end

  always_ff @(posedge clock) begin
    if (push) ras[ptr_q] <= pc_inc;
  end

  assign bus.pc            = pc_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_empty     = ras_empty_w;
  assign bus.ras_full      = ras_full_w;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, wrap, stall/redirect, call/return nesting, RAS overflow and flag clearing.
module tb_pc_unit;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  pc_unit_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH       (16),
    .RESET_VECTOR(16'h0000),
    .STEP        (1),
    .RAS_DEPTH   (4)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.stall           = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.branch          = 1'b0;
    bus.jump            = 1'b0;
    bus.call            = 1'b0;
    bus.ret             = 1'b0;
    bus.target          = '0;
    bus.err_clear       = 1'b0;
  endtask

  task automatic go_to(input logic [15:0] addr);
    idle();
    bus.redirect        = 1'b1;
    bus.redirect_target = addr;
    tick();
    idle();
    check("redirect_load", 32'(bus.pc), 32'(addr));
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    reset = 1'b0;

    // Reset state and sequential increment
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc",    32'(bus.pc), 32'h0);
    check("rst_count", 32'(bus.ras_count), 32'd0);
    check("rst_empty", 32'(bus.ras_empty), 32'd1);
    check("rst_full",  32'(bus.ras_full), 32'd0);
    check("rst_ovf",   32'(bus.ras_overflow), 32'd0);
    check("rst_unf",   32'(bus.ras_underflow), 32'd0);
    reset = 1'b1;
    #1;
    check("release_pc", 32'(bus.pc), 32'h0);
    for (int unsigned i = 1; i <= 5; i++) begin
      tick();
      check("incr_pc", 32'(bus.pc), 32'(i));
    end
    #2 reset = 1'b0;
    #1 check("async_rst_pc", 32'(bus.pc), 32'h0);
    reset = 1'b1;
    tick();
    check("after_rst_pc", 32'(bus.pc), 32'h1);

    // Wrap from max to zero, no flags
    go_to(16'hFFFE);
    tick(); check("wrap_ffff", 32'(bus.pc), 32'hFFFF);
    tick(); check("wrap_0000", 32'(bus.pc), 32'h0000);
    tick(); check("wrap_0001", 32'(bus.pc), 32'h0001);
    check("wrap_ovf", 32'(bus.ras_overflow), 32'd0);
    check("wrap_unf", 32'(bus.ras_underflow), 32'd0);

    // Stall holds against jump; redirect overrides stall
    go_to(16'h0010);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.target = 16'h0040;
    tick(); check("stall_hold1", 32'(bus.pc), 32'h0010);
    tick(); check("stall_hold2", 32'(bus.pc), 32'h0010);
    bus.redirect = 1'b1; bus.redirect_target = 16'h0080;
    tick(); check("stall_redirect", 32'(bus.pc), 32'h0080);
    idle();
    bus.branch = 1'b1; bus.target = 16'h0321;
    tick(); check("branch_pc", 32'(bus.pc), 32'h0321);
    idle();
    bus.jump = 1'b1; bus.target = 16'h0654;
    tick(); check("jump_pc", 32'(bus.pc), 32'h0654);
    check("jump_count", 32'(bus.ras_count), 32'd0);

    // Call/return nesting
    go_to(16'h0010);
    bus.call = 1'b1; bus.target = 16'h0100;
    tick(); check("nest_pc1", 32'(bus.pc), 32'h0100); check("nest_cnt1", 32'(bus.ras_count), 32'd1);
    idle();
    tick(); check("nest_pc2", 32'(bus.pc), 32'h0101); check("nest_cnt2", 32'(bus.ras_count), 32'd1);
    bus.call = 1'b1; bus.target = 16'h0200;
    tick(); check("nest_pc3", 32'(bus.pc), 32'h0200); check("nest_cnt3", 32'(bus.ras_count), 32'd2);
    idle(); bus.ret = 1'b1;
    tick(); check("nest_pc4", 32'(bus.pc), 32'h0102); check("nest_cnt4", 32'(bus.ras_count), 32'd1);
    tick(); check("nest_pc5", 32'(bus.pc), 32'h0011); check("nest_cnt5", 32'(bus.ras_count), 32'd0);
    check("nest_empty", 32'(bus.ras_empty), 32'd1);
    idle();

    // Overflow: five nested calls from 0x1000, 0x2000 ... 0x5000
    go_to(16'h1000);
    for (int unsigned i = 0; i < 5; i++) begin
      bus.call = 1'b1; bus.target = 16'((i + 2) << 12);
      tick();
      check("ovf_call_pc", 32'(bus.pc), (i + 2) << 12);
      check("ovf_call_flag", 32'(bus.ras_overflow), (i == 4) ? 32'd1 : 32'd0);
    end
    idle();
    check("ovf_full",  32'(bus.ras_full), 32'd1);
    check("ovf_count", 32'(bus.ras_count), 32'd4);
    check("ovf_unf",   32'(bus.ras_underflow), 32'd0);
    ret_exp[0] = 16'h5001; ret_exp[1] = 16'h4001; ret_exp[2] = 16'h3001; ret_exp[3] = 16'h2001;
    bus.ret = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("ovf_ret_pc",  32'(bus.pc), 32'(ret_exp[i]));
      check("ovf_ret_cnt", 32'(bus.ras_count), 32'(3 - i));
    end
    check("ovf_unf_before", 32'(bus.ras_underflow), 32'd0);
    tick();
    check("unf_pc",    32'(bus.pc), 32'h2002);
    check("unf_flag",  32'(bus.ras_underflow), 32'd1);
    check("unf_count", 32'(bus.ras_count), 32'd0);
    check("unf_ovf",   32'(bus.ras_overflow), 32'd1);

    // err_clear with no event drops both flags
    idle(); bus.err_clear = 1'b1;
    tick();
    check("clr_pc",  32'(bus.pc), 32'h2003);
    check("clr_ovf", 32'(bus.ras_overflow), 32'd0);
    check("clr_unf", 32'(bus.ras_underflow), 32'd0);

    // call+jump acts as call; ret+call takes ret without pushing
    idle(); bus.call = 1'b1; bus.jump = 1'b1; bus.target = 16'h0700;
    tick();
    check("calljmp_pc",  32'(bus.pc), 32'h0700);
    check("calljmp_cnt", 32'(bus.ras_count), 32'd1);
    idle(); bus.ret = 1'b1; bus.call = 1'b1; bus.target = 16'h0900;
    tick();
    check("retcall_pc",  32'(bus.pc), 32'h2004);
    check("retcall_cnt", 32'(bus.ras_count), 32'd0);

    // err_clear coinciding with underflow: set wins
    idle(); bus.ret = 1'b1; bus.err_clear = 1'b1;
    tick();
    check("setwins_pc",  32'(bus.pc), 32'h2005);
    check("setwins_unf", 32'(bus.ras_underflow), 32'd1);
    idle(); bus.err_clear = 1'b1;
    tick();
    check("final_clr_unf", 32'(bus.ras_underflow), 32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
